// File: rtl/mult_acc_pkg.sv
// Shared types and default widths for the mult64 product accumulator.
package mult_acc_pkg;

    typedef enum logic {
        IDLE,
        ACCUM
    } state_t;

    localparam int DEF_PROD_W = 128;
    localparam int DEF_ACC_W  = 136;

    // Operand register plus result register inside the mult64 wrapper.
    localparam int MULT64_LAT = 2;

endpackage

// File: rtl/mult_acc_fifo.sv
// First-word-fall-through FIFO with occupancy count; push and pop may coincide even when full.
module mult_acc_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; emptiness is tracked by count, and pop_data is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/mult_acc_stage.sv
// Accumulates the mult64 product stream into dot-product sums behind a credit-throttled issue port.
// Define MULT_ACC_SAT_EN to saturate the accumulator on overflow instead of wrapping.
module mult_acc_stage
    import mult_acc_pkg::*;
#(
    parameter int PROD_W    = DEF_PROD_W,
    parameter int ACC_W     = DEF_ACC_W,
    parameter int MULT_LAT  = MULT64_LAT,
    parameter int OUT_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid,
    input  logic              issue_last,
    output logic              issue_ready,
    input  logic [PROD_W-1:0] product,
    output logic [ACC_W-1:0]  out_data,
    output logic              out_ovf,
    output logic              out_valid,
    input  logic              out_ready
);
    localparam int CW = $clog2(OUT_DEPTH + 1);

    logic                issue_fire;
    logic [MULT_LAT-1:0] fire_dl;
    logic [MULT_LAT-1:0] last_dl;
    logic                p_vld;
    logic                p_last;

    state_t              state, state_d;
    logic [ACC_W-1:0]    acc, acc_d;
    logic                ovf, ovf_d;
    logic [ACC_W-1:0]    prod_ext;
    logic [ACC_W:0]      sum_full;
    logic                carry;
    logic [ACC_W-1:0]    acc_upd;

    logic                push;
    logic [ACC_W:0]      push_data;
    logic                fifo_pop;
    logic                fifo_empty;
    logic                fifo_full;
    logic [CW-1:0]       fifo_count;
    int                  pend;
    int                  pend_next;
    int                  count_next;

    assign issue_fire = issue_valid & issue_ready;
    assign p_vld      = fire_dl[MULT_LAT-1];
    assign p_last     = last_dl[MULT_LAT-1];

    // last_dl only ever holds fired last flags, so its popcount is the credit in flight.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            fire_dl <= '0;
            last_dl <= '0;
        end else begin
            fire_dl[0] <= issue_fire;
            last_dl[0] <= issue_fire & issue_last;
            for (int i = MULT_LAT - 1; i > 0; i--) begin
                fire_dl[i] <= fire_dl[i-1];
                last_dl[i] <= last_dl[i-1];
            end
        end
    end

    assign prod_ext = ACC_W'(product);
    assign sum_full = {1'b0, acc} + {1'b0, prod_ext};
    assign carry    = sum_full[ACC_W];

`ifdef MULT_ACC_SAT_EN
    assign acc_upd = carry ? '1 : sum_full[ACC_W-1:0];
`else
    assign acc_upd = sum_full[ACC_W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            acc   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_d;
            acc   <= acc_d;
            ovf   <= ovf_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_d   = state;
        acc_d     = acc;
        ovf_d     = ovf;
        push      = 1'b0;
        push_data = '0;
        if (p_vld) begin
            case (state)
                IDLE: begin
                    if (p_last) begin
                        push      = 1'b1;
                        push_data = {prod_ext, 1'b0};
                    end else begin
                        acc_d   = prod_ext;
                        ovf_d   = 1'b0;
                        state_d = ACCUM;
                    end
                end
                ACCUM: begin
                    if (p_last) begin
                        push      = 1'b1;
                        push_data = {acc_upd, ovf | carry};
                        acc_d     = '0;
                        ovf_d     = 1'b0;
                        state_d   = IDLE;
                    end else begin
                        acc_d = acc_upd;
                        ovf_d = ovf | carry;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign fifo_pop  = out_valid & out_ready;
    assign out_valid = ~fifo_empty;

    mult_acc_fifo #(
        .WIDTH (ACC_W + 1),
        .DEPTH (OUT_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (fifo_pop),
        .pop_data  ({out_data, out_ovf}),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    // Ready is registered from the occupancy and credits the registers will hold after this edge.
    always_comb begin
        pend = 0;
        for (int i = 0; i < MULT_LAT; i++) pend += int'(last_dl[i]);
        pend_next  = pend + int'(issue_fire & issue_last) - int'(p_last);
        count_next = int'(fifo_count) + int'(push) - int'(fifo_pop);
    end

    always_ff @(posedge clk) begin
        if (reset) issue_ready <= 1'b1;
        else       issue_ready <= (count_next + pend_next) < OUT_DEPTH;
    end

endmodule

// File: tb/tb_mult_acc_stage.sv
// Scoreboard bench for mult_acc_stage: directed groups, monitor pops expected sums on every handshake.
module tb_mult_acc_stage;
    localparam int PW    = 128;
    localparam int AW    = 129;
    localparam int LAT   = 2;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic [AW-1:0] data;
        logic          ovf;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          issue_valid;
    logic          issue_last;
    logic          issue_ready;
    logic [PW-1:0] product;
    logic [AW-1:0] out_data;
    logic          out_ovf;
    logic          out_valid;
    logic          out_ready;

    logic [PW-1:0] pin;
    logic [PW-1:0] p0;
    exp_t          sb[$];
    int            total = 0;
    int            bad   = 0;

    mult_acc_stage #(
        .PROD_W    (PW),
        .ACC_W     (AW),
        .MULT_LAT  (LAT),
        .OUT_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_last  (issue_last),
        .issue_ready (issue_ready),
        .product     (product),
        .out_data    (out_data),
        .out_ovf     (out_ovf),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    always #5 clk = ~clk;

    // Stand-in for mult64: two register stages from operands to product.
    always @(posedge clk) begin
        p0      <= pin;
        product <= p0;
    end

    task automatic check(input string name, input logic [AW:0] act, input logic [AW:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_sum(input logic [AW-1:0] data, input logic ovf);
        exp_t e;
        e.data = data;
        e.ovf  = ovf;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [PW-1:0] p, input logic last);
        int n = 0;
        while (!issue_ready && n < 100) begin
            tick();
            n++;
        end
        if (!issue_ready) begin
            total++;
            bad++;
            $display("FAIL issue_wait: issue_ready stuck at 0 after %0d cycles", n);
        end
        issue_valid = 1'b1;
        issue_last  = last;
        pin         = p;
        tick();
        issue_valid = 1'b0;
        issue_last  = 1'b0;
        pin         = 128'hdead_beef_0bad_f00d_dead_beef_0bad_f00d;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < 200) begin
            tick();
            n++;
        end
        if (sb.size() != 0 || out_valid) begin
            total++;
            bad++;
            $display("FAIL drain: %0d sums still expected, out_valid=%0b", sb.size(), out_valid);
        end
        tick();
        tick();
    endtask

    // Monitor: compares every accepted output against the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset && dut.push) check("push_vs_full", {{AW{1'b0}}, dut.fifo_full}, '0);
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got data=%h ovf=%0b, expected none", out_data, out_ovf);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_data", {1'b0, out_data}, {1'b0, e.data});
                check("out_ovf", {{AW{1'b0}}, out_ovf}, {{AW{1'b0}}, e.ovf});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] all_ones;
        logic [AW-1:0] two_m;
        logic [AW-1:0] three_m_wrap;
        logic [PW-1:0] m;

        reset       = 1'b1;
        issue_valid = 1'b0;
        issue_last  = 1'b0;
        out_ready   = 1'b1;
        pin         = '0;
        repeat (3) tick();

        check("rst_issue_ready", {{AW{1'b0}}, issue_ready}, {{AW{1'b0}}, 1'b1});
        check("rst_out_valid", {{AW{1'b0}}, out_valid}, '0);
        check("rst_out_data", {1'b0, out_data}, '0);
        check("rst_out_ovf", {{AW{1'b0}}, out_ovf}, '0);
        reset = 1'b0;
        tick();

        // Single term 3*5: visible MULT_LAT edges after the fire edge.
        expect_sum(AW'(15), 1'b0);
        issue(PW'(3 * 5), 1'b1);
        tick();
        check("t1_not_yet", {{AW{1'b0}}, out_valid}, '0);
        tick();
        check("t1_valid", {{AW{1'b0}}, out_valid}, {{AW{1'b0}}, 1'b1});
        check("t1_data", {1'b0, out_data}, (AW + 1)'(15));
        drain();

        // Four back-to-back terms 1+2+3+4.
        expect_sum(AW'(10), 1'b0);
        issue(PW'(1), 1'b0);
        issue(PW'(2), 1'b0);
        issue(PW'(3), 1'b0);
        issue(PW'(4), 1'b1);
        tick();
        check("t2_not_yet", {{AW{1'b0}}, out_valid}, '0);
        tick();
        check("t2_valid", {{AW{1'b0}}, out_valid}, {{AW{1'b0}}, 1'b1});
        drain();

        // Backpressure: two credits consumed, third group waits for a pop.
        out_ready = 1'b0;
        expect_sum(AW'(11), 1'b0);
        expect_sum(AW'(22), 1'b0);
        expect_sum(AW'(33), 1'b0);
        issue(PW'(11), 1'b1);
        issue(PW'(22), 1'b1);
        check("t3_ready_low", {{AW{1'b0}}, issue_ready}, '0);
        repeat (3) tick();
        check("t3_ready_held", {{AW{1'b0}}, issue_ready}, '0);
        check("t3_head", {1'b0, out_data}, (AW + 1)'(11));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t3_ready_back", {{AW{1'b0}}, issue_ready}, {{AW{1'b0}}, 1'b1});
        issue(PW'(33), 1'b1);
        repeat (4) tick();
        out_ready = 1'b1;
        drain();

        // Overflow at ACC_W = 129 with products of 2^128-1.
        m            = '1;
        all_ones     = '1;
        two_m        = all_ones - AW'(1);
        three_m_wrap = {1'b0, m} - AW'(2);
        expect_sum(two_m, 1'b0);
        issue(m, 1'b0);
        issue(m, 1'b1);
`ifdef MULT_ACC_SAT_EN
        expect_sum(all_ones, 1'b1);
`else
        expect_sum(three_m_wrap, 1'b1);
`endif
        issue(m, 1'b0);
        issue(m, 1'b0);
        issue(m, 1'b1);
        drain();

        // Reset while a group is partially accumulated and a term is in flight.
        issue(PW'(7), 1'b0);
        issue(PW'(9), 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_ready", {{AW{1'b0}}, issue_ready}, {{AW{1'b0}}, 1'b1});
        check("t5_no_output", {{AW{1'b0}}, out_valid}, '0);
        repeat (4) tick();
        expect_sum(AW'(10), 1'b0);
        issue(PW'(4), 1'b0);
        issue(PW'(6), 1'b1);
        drain();

        // Bubbles between terms leave the accumulator untouched.
        expect_sum(AW'(15), 1'b0);
        issue(PW'(7), 1'b0);
        repeat (3) tick();
        issue(PW'(8), 1'b1);
        drain();

        check("sb_empty", (AW + 1)'(sb.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
